// File: rtl/stack_sequencer.sv
// rtl/stack_sequencer.sv - operand-stack sequencer: opcode handshake, stack RAM sequencing, ALU and fault checks
module stack_sequencer #(
  parameter  int DATA_W = 17,
  parameter  int DEPTH  = 32,
  parameter  int PC_W   = 10,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [7:0]        op_code,
  input  logic [DATA_W-1:0] op_imm,
  output logic              op_done,
  output logic              jump_taken,
  output logic [PC_W-1:0]   jump_target,
  output logic [AW-1:0]     st_addr,
  output logic              st_wr_en,
  output logic [DATA_W-1:0] st_wdata,
  input  logic [DATA_W-1:0] st_rdata,
  output logic [AW:0]       sp,
  output logic              halted,
  output logic [1:0]        fault
);

  // Opcode values shared with fetch
  localparam logic [7:0] OP_STOP   = 8'h00;
  localparam logic [7:0] OP_ADD    = 8'h01;
  localparam logic [7:0] OP_MUL    = 8'h02;
  localparam logic [7:0] OP_LT     = 8'h10;
  localparam logic [7:0] OP_EQ     = 8'h14;
  localparam logic [7:0] OP_ISZERO = 8'h15;
  localparam logic [7:0] OP_POP    = 8'h50;
  localparam logic [7:0] OP_JUMPI  = 8'h57;
  localparam logic [7:0] OP_PUSH0  = 8'h5F;
  localparam logic [7:0] OP_PUSH1  = 8'h60;
  localparam logic [7:0] OP_DUP1   = 8'h80;

  typedef enum logic [2:0] {S_IDLE, S_RD0, S_RD1, S_WB, S_HALT, S_FAULT} state_t;

  state_t              state;
  logic [7:0]          op_q;
  logic [DATA_W-1:0]   imm_q;
  logic [DATA_W-1:0]   s0;

  function automatic logic op_defined(input logic [7:0] c);
    case (c)
      OP_STOP, OP_ADD, OP_MUL, OP_LT, OP_EQ, OP_ISZERO,
      OP_POP, OP_JUMPI, OP_PUSH0, OP_PUSH1, OP_DUP1: op_defined = 1'b1;
      default:                                       op_defined = 1'b0;
    endcase
  endfunction

  // Number of stack entries an opcode consumes as operands
  function automatic logic [1:0] op_need(input logic [7:0] c);
    case (c)
      OP_ADD, OP_MUL, OP_LT, OP_EQ, OP_JUMPI: op_need = 2'd2;
      OP_ISZERO, OP_POP, OP_DUP1:             op_need = 2'd1;
      default:                                op_need = 2'd0;
    endcase
  endfunction

  function automatic logic op_pushes(input logic [7:0] c);
    op_pushes = (c == OP_PUSH0) || (c == OP_PUSH1) || (c == OP_DUP1);
  endfunction

  assign op_ready = (state == S_IDLE);

  // Main sequencer: accept/check, read operands, then a single write-back cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      sp       <= '0;
      op_q     <= '0;
      imm_q    <= '0;
      s0       <= '0;
      st_addr  <= '0;
      st_wr_en <= 1'b0;
      op_done  <= 1'b0;
      halted   <= 1'b0;
      fault    <= 2'd0;
    end else begin
      st_wr_en <= 1'b0;
      op_done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (op_valid) begin
            op_q  <= op_code;
            imm_q <= op_imm;
            if (!op_defined(op_code)) begin
              state  <= S_FAULT;
              fault  <= 2'd3;
              halted <= 1'b1;
            end else if ((AW+1)'(op_need(op_code)) > sp) begin
              state  <= S_FAULT;
              fault  <= 2'd1;
              halted <= 1'b1;
            end else if (op_pushes(op_code) && (sp == (AW+1)'(DEPTH))) begin
              state  <= S_FAULT;
              fault  <= 2'd2;
              halted <= 1'b1;
            end else if (op_code == OP_STOP) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else if ((op_code == OP_PUSH0) || (op_code == OP_PUSH1)) begin
              state    <= S_WB;
              st_addr  <= sp[AW-1:0];
              st_wr_en <= 1'b1;
              op_done  <= 1'b1;
            end else if (op_code == OP_POP) begin
              state   <= S_WB;
              op_done <= 1'b1;
            end else begin
              state   <= S_RD0;
              st_addr <= sp[AW-1:0] - AW'(1);
            end
          end
        end
        S_RD0: begin
          if (op_need(op_q) == 2'd2) begin
            state   <= S_RD1;
            st_addr <= sp[AW-1:0] - AW'(2);
          end else begin
            // ISZERO rewrites the top in place; DUP1 writes one slot above it
            state    <= S_WB;
            st_addr  <= (op_q == OP_DUP1) ? sp[AW-1:0] : sp[AW-1:0] - AW'(1);
            st_wr_en <= 1'b1;
            op_done  <= 1'b1;
          end
        end
        S_RD1: begin
          s0       <= st_rdata;
          state    <= S_WB;
          st_wr_en <= (op_q != OP_JUMPI);
          op_done  <= 1'b1;
        end
        S_WB: begin
          state <= S_IDLE;
          case (op_q)
            OP_PUSH0, OP_PUSH1, OP_DUP1: sp <= sp + (AW+1)'(1);
            OP_JUMPI:                    sp <= sp - (AW+1)'(2);
            OP_ISZERO:                   sp <= sp;
            default:                     sp <= sp - (AW+1)'(1);
          endcase
        end
        S_HALT, S_FAULT: state <= state;
        default:         state <= S_IDLE;
      endcase
    end
  end

  // Write data and branch outcome use the operand arriving from RAM during write-back
  always_comb begin
    st_wdata    = '0;
    jump_taken  = 1'b0;
    jump_target = '0;
    if (state == S_WB) begin
      case (op_q)
        OP_ADD:    st_wdata = s0 + st_rdata;
        OP_MUL:    st_wdata = s0 * st_rdata;
        OP_LT:     st_wdata = DATA_W'(s0 < st_rdata);
        OP_EQ:     st_wdata = DATA_W'(s0 == st_rdata);
        OP_ISZERO: st_wdata = DATA_W'(st_rdata == '0);
        OP_PUSH1:  st_wdata = imm_q;
        OP_DUP1:   st_wdata = st_rdata;
        OP_JUMPI: begin
          jump_taken  = (st_rdata != '0);
          jump_target = s0[PC_W-1:0];
        end
        default:   st_wdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// tb/tb_stack_sequencer.sv - scoreboard bench for stack_sequencer
module tb_stack_sequencer;
  localparam int DATA_W = 17;
  localparam int DEPTH  = 32;
  localparam int PC_W   = 10;
  localparam int AW     = 5;

  localparam logic [7:0] OP_STOP   = 8'h00;
  localparam logic [7:0] OP_ADD    = 8'h01;
  localparam logic [7:0] OP_MUL    = 8'h02;
  localparam logic [7:0] OP_LT     = 8'h10;
  localparam logic [7:0] OP_EQ     = 8'h14;
  localparam logic [7:0] OP_ISZERO = 8'h15;
  localparam logic [7:0] OP_POP    = 8'h50;
  localparam logic [7:0] OP_JUMPI  = 8'h57;
  localparam logic [7:0] OP_PUSH0  = 8'h5F;
  localparam logic [7:0] OP_PUSH1  = 8'h60;
  localparam logic [7:0] OP_DUP1   = 8'h80;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              op_valid = 1'b0;
  logic              op_ready;
  logic [7:0]        op_code = '0;
  logic [DATA_W-1:0] op_imm = '0;
  logic              op_done;
  logic              jump_taken;
  logic [PC_W-1:0]   jump_target;
  logic [AW-1:0]     st_addr;
  logic              st_wr_en;
  logic [DATA_W-1:0] st_wdata;
  logic [DATA_W-1:0] st_rdata;
  logic [AW:0]       sp;
  logic              halted;
  logic [1:0]        fault;

  stack_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_imm(op_imm), .op_done(op_done),
    .jump_taken(jump_taken), .jump_target(jump_target),
    .st_addr(st_addr), .st_wr_en(st_wr_en), .st_wdata(st_wdata),
    .st_rdata(st_rdata), .sp(sp), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (st_wr_en) mem[st_addr] <= st_wdata;
    st_rdata <= mem[st_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int code; int wr; int addr; int wdata; int jt; int jtgt; int spa; int lat; int acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vec = 0;
  int   miss = 0;
  int   wr_cnt = 0;
  bit   pend = 0;
  int   sp_exp = 0;
  int   w0;
  int   bad;

  function automatic void chk(string nm, int act, int req);
    vec++;
    if (act != req) begin
      miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endfunction

  task automatic issue(input logic [7:0] c, input int imm, input bit track, input exp_t e);
    int n;
    @(negedge clk);
    op_code  = c;
    op_imm   = imm[DATA_W-1:0];
    op_valid = 1'b1;
    n = 0;
    while (!op_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!op_ready) begin
      chk($sformatf("accept_timeout op%0h", c), int'(op_ready), 1);
      op_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      if (track) begin
        e.acc = cyc;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic op(input logic [7:0] c, input int imm, input int wr, input int addr,
                    input int wdata, input int jt, input int jtgt, input int spa, input int lat);
    exp_t e;
    e.code = int'(c); e.wr = wr; e.addr = addr; e.wdata = wdata;
    e.jt = jt; e.jtgt = jtgt; e.spa = spa; e.lat = lat; e.acc = 0;
    issue(c, imm, 1'b1, e);
  endtask

  task automatic op_nt(input logic [7:0] c, input int imm);
    exp_t e;
    e = '{default: 0};
    issue(c, imm, 1'b0, e);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || pend) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("drain_timeout", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    op_valid = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on every retirement and checks the write-back cycle
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      pend = 0;
    end else begin
      if (st_wr_en) begin
        wr_cnt++;
        chk("wr_without_done", int'(op_done), 1);
      end
      if (op_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", int'(op_done), 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk($sformatf("latency op%0h", mon_e.code), cyc - mon_e.acc + 1, mon_e.lat);
          chk($sformatf("wr_en op%0h", mon_e.code), int'(st_wr_en), mon_e.wr);
          if (mon_e.wr != 0) begin
            chk($sformatf("addr op%0h", mon_e.code), int'(st_addr), mon_e.addr);
            chk($sformatf("wdata op%0h", mon_e.code), int'(st_wdata), mon_e.wdata);
          end
          if (mon_e.code == int'(OP_JUMPI)) begin
            chk("jump_taken", int'(jump_taken), mon_e.jt);
            chk("jump_target", int'(jump_target), mon_e.jtgt);
          end
          pend = 1;
          sp_exp = mon_e.spa;
        end
      end else if (pend) begin
        chk("sp_after", int'(sp), sp_exp);
        chk("ready_after", int'(op_ready), 1);
        pend = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    @(negedge clk);
    chk("rst_op_ready", int'(op_ready), 1);
    chk("rst_sp", int'(sp), 0);
    chk("rst_wr_en", int'(st_wr_en), 0);
    chk("rst_op_done", int'(op_done), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_addr", int'(st_addr), 0);
    chk("rst_wdata", int'(st_wdata), 0);
    chk("rst_jump", int'({jump_taken, jump_target}), 0);
    rst = 1'b1;
    @(negedge clk);

    // arithmetic chain
    w0 = wr_cnt;
    op(OP_PUSH1, 3, 1, 0, 3, 0, 0, 1, 1);
    op(OP_PUSH1, 4, 1, 1, 4, 0, 0, 2, 1);
    op(OP_ADD, 0, 1, 0, 7, 0, 0, 1, 3);
    op(OP_PUSH1, 5, 1, 1, 5, 0, 0, 2, 1);
    op(OP_MUL, 0, 1, 0, 35, 0, 0, 1, 3);
    op(OP_PUSH1, 40, 1, 1, 40, 0, 0, 2, 1);
    op(OP_LT, 0, 1, 0, 0, 0, 0, 1, 3);
    op(OP_ISZERO, 0, 1, 0, 1, 0, 0, 1, 2);
    op(OP_DUP1, 0, 1, 1, 1, 0, 0, 2, 2);
    op(OP_POP, 0, 0, 0, 0, 0, 0, 1, 1);
    op(OP_PUSH0, 0, 1, 1, 0, 0, 0, 2, 1);
    op(OP_LT, 0, 1, 0, 1, 0, 0, 1, 3);
    drain();
    chk("chain_write_count", wr_cnt - w0, 11);

    // wrap-around add, dup/eq, truncated multiply
    do_reset();
    op(OP_PUSH1, 'h1FFFF, 1, 0, 'h1FFFF, 0, 0, 1, 1);
    op(OP_PUSH1, 2, 1, 1, 2, 0, 0, 2, 1);
    op(OP_ADD, 0, 1, 0, 1, 0, 0, 1, 3);
    op(OP_DUP1, 0, 1, 1, 1, 0, 0, 2, 2);
    op(OP_EQ, 0, 1, 0, 1, 0, 0, 1, 3);
    op(OP_PUSH1, 'h1FFFF, 1, 1, 'h1FFFF, 0, 0, 2, 1);
    op(OP_PUSH1, 'h1FFFF, 1, 2, 'h1FFFF, 0, 0, 3, 1);
    op(OP_MUL, 0, 1, 1, 1, 0, 0, 2, 3);
    drain();

    // underflow straight after reset
    do_reset();
    w0 = wr_cnt;
    op_nt(OP_ADD, 0);
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (op_ready) bad++;
    end
    chk("uf_ready_low", bad, 0);
    chk("uf_fault", int'(fault), 1);
    chk("uf_halted", int'(halted), 1);
    chk("uf_sp", int'(sp), 0);
    chk("uf_writes", wr_cnt - w0, 0);

    // fill to DEPTH then overflow
    do_reset();
    for (int i = 0; i < DEPTH; i++) op(OP_PUSH0, 0, 1, i, 0, 0, 0, i + 1, 1);
    drain();
    chk("full_sp", int'(sp), 32);
    w0 = wr_cnt;
    op_nt(OP_PUSH1, 5);
    repeat (4) @(negedge clk);
    chk("of_fault", int'(fault), 2);
    chk("of_halted", int'(halted), 1);
    chk("of_sp", int'(sp), 32);
    chk("of_writes", wr_cnt - w0, 0);
    chk("of_ready", int'(op_ready), 0);

    // conditional jump taken / not taken
    do_reset();
    op(OP_PUSH1, 1, 1, 0, 1, 0, 0, 1, 1);
    op(OP_PUSH1, 'h2A, 1, 1, 'h2A, 0, 0, 2, 1);
    op(OP_JUMPI, 0, 0, 0, 0, 1, 'h2A, 0, 3);
    op(OP_PUSH1, 0, 1, 0, 0, 0, 0, 1, 1);
    op(OP_PUSH1, 'h15, 1, 1, 'h15, 0, 0, 2, 1);
    op(OP_JUMPI, 0, 0, 0, 0, 0, 'h15, 0, 3);
    drain();

    // reset during MUL operand read, then STOP
    do_reset();
    op(OP_PUSH1, 6, 1, 0, 6, 0, 0, 1, 1);
    op(OP_PUSH1, 7, 1, 1, 7, 0, 0, 2, 1);
    drain();
    w0 = wr_cnt;
    op_nt(OP_MUL, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_wr_en", int'(st_wr_en), 0);
    chk("abort_sp", int'(sp), 0);
    chk("abort_done", int'(op_done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ready", int'(op_ready), 1);
    repeat (4) @(negedge clk);
    chk("abort_writes", wr_cnt - w0, 0);
    op_nt(OP_STOP, 0);
    repeat (3) @(negedge clk);
    chk("stop_halted", int'(halted), 1);
    chk("stop_fault", int'(fault), 0);
    chk("stop_ready", int'(op_ready), 0);

    // undefined opcode
    do_reset();
    op_nt(8'hFF, 0);
    repeat (3) @(negedge clk);
    chk("undef_fault", int'(fault), 3);
    chk("undef_halted", int'(halted), 1);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
